// File: rtl/mxn_encoder_pkg.sv
// Shared types, constants and width helpers for the mxn encoder family.
package mxn_encoder_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_e;

  localparam int PRIO_LSB = 0;
  localparam int PRIO_MSB = 1;

  // Index width; never below one bit so narrow vectors still get a port.
  function automatic int IDX_W(input int dw);
    return (dw < 2) ? 1 : $clog2(dw);
  endfunction

  // Count width; must be able to hold dw itself (all-ones vector).
  function automatic int CNT_W(input int dw);
    return $clog2(dw + 1);
  endfunction

endpackage

// File: rtl/mxn_seq_encoder_if.sv
// Request/beat bus between a vector source, the sequential encoder and an
// index consumer.
interface mxn_seq_encoder_if #(
  parameter int DATA_WIDTH = 16
) ();
  import mxn_encoder_pkg::*;

  localparam int IW = IDX_W(DATA_WIDTH);
  localparam int CW = CNT_W(DATA_WIDTH);

  logic                  s_valid;
  logic                  s_ready;
  logic [DATA_WIDTH-1:0] s_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [IW-1:0]         m_index;
  logic                  m_last;
  logic                  m_empty;
  logic [CW-1:0]         m_count;

  // Encoder side: takes vectors in, hands index beats out.
  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_index, m_last, m_empty, m_count
  );

  // Environment side: supplies vectors and consumes beats.
  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_index, m_last, m_empty, m_count
  );

endinterface

// File: rtl/mxn_encoder.sv
// Combinational priority encoder: index of the lowest or highest set bit.
// index_out is 0 and valid_out is 0 for an all-zero input.
module mxn_encoder
  import mxn_encoder_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int PRIORITY_TYPE = PRIO_LSB
) (
  input  logic [DATA_WIDTH-1:0]        data_in,
  output logic [IDX_W(DATA_WIDTH)-1:0] index_out,
  output logic                         valid_out
);

  localparam int IW = IDX_W(DATA_WIDTH);

  // Scan so that the winning bit is the last one assigned.
  always_comb begin
    index_out = '0;
    valid_out = |data_in;
    if (PRIORITY_TYPE == PRIO_MSB) begin
      for (int i = 0; i < DATA_WIDTH; i++) begin
        if (data_in[i]) index_out = IW'(i);
      end
    end else begin
      for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
        if (data_in[i]) index_out = IW'(i);
      end
    end
  end

endmodule

// File: rtl/mxn_seq_encoder.sv
// Multi-hit encoder: captures a request vector and emits the index of each
// set bit, one beat per cycle, lowest- or highest-first. An all-zero vector
// still produces one beat flagged m_empty.
module mxn_seq_encoder
  import mxn_encoder_pkg::*;
#(
  parameter int DATA_WIDTH    = 16,
  parameter int PRIORITY_TYPE = PRIO_LSB
) (
  input  logic               clk,
  input  logic               rst,
  mxn_seq_encoder_if.slave   bus
);

  localparam int IW = IDX_W(DATA_WIDTH);
  localparam int CW = CNT_W(DATA_WIDTH);

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] pend_q, pend_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  empty_q, empty_d;

  logic [IW-1:0]         enc_idx;
  logic                  enc_valid;
  logic                  busy;
  logic                  last_beat;
  logic                  s_ready;

  function automatic logic [CW-1:0] popcount(input logic [DATA_WIDTH-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < DATA_WIDTH; i++) c = c + CW'(v[i]);
    return c;
  endfunction

  function automatic logic at_most_one(input logic [DATA_WIDTH-1:0] v);
    return (v & (v - DATA_WIDTH'(1))) == '0;
  endfunction

  mxn_encoder #(
    .DATA_WIDTH   (DATA_WIDTH),
    .PRIORITY_TYPE(PRIORITY_TYPE)
  ) u_enc (
    .data_in  (pend_q),
    .index_out(enc_idx),
    .valid_out(enc_valid)
  );

  assign busy      = (state_q == BUSY);
  assign last_beat = at_most_one(pend_q);

  // Next-state: capture on accept, retire one bit per transferred beat.
  // The last beat frees the slot in the same cycle so a waiting vector
  // is taken without a bubble.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    count_d = count_q;
    empty_d = empty_q;
    s_ready = 1'b0;
    case (state_q)
      IDLE: begin
        s_ready = 1'b1;
        if (bus.s_valid) begin
          pend_d  = bus.s_data;
          count_d = popcount(bus.s_data);
          empty_d = (bus.s_data == '0);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (bus.m_ready) begin
          if (!last_beat) begin
            if (enc_valid) pend_d[enc_idx] = 1'b0;
          end else begin
            s_ready = 1'b1;
            pend_d  = '0;
            if (bus.s_valid) begin
              pend_d  = bus.s_data;
              count_d = popcount(bus.s_data);
              empty_d = (bus.s_data == '0);
            end else begin
              state_d = IDLE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Refuse input while reset is asserted.
    if (rst) s_ready = 1'b0;
  end

  // State and captured-vector registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      count_q <= '0;
      empty_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      count_q <= count_d;
      empty_q <= empty_d;
    end
  end

  // Outputs come only from registers (plus m_ready for s_ready).
  assign bus.s_ready = s_ready;
  assign bus.m_valid = busy;
  assign bus.m_index = enc_idx;
  assign bus.m_last  = busy & last_beat;
  assign bus.m_empty = empty_q;
  assign bus.m_count = count_q;

endmodule
